serial_adder_sequencer: RTL and testbench

Bit-serial operand sequencer and result collector placed directly around a single 1-bit CLRCL full-adder cell. It accepts two N-bit words through a valid/ready handshake and drives them into the cell one bit per step, LSB first, as rail-to-rail xreal levels. It also drives both carry polarities, since the CLRCL cell needs true and complement carry. After each settling window it samples the cell's Sout/Cout back, then returns the N-bit sum, carry-out and signed overflow through a second handshake.

---
 rtl/serial_adder_sequencer.sv | 145 ++++++++++++++
 tb/tb_serial_adder_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sequencer.sv
// Bit-serial operand sequencer and result collector wrapped around a CLRCL full-adder cell.
// Optional subtract support via `define SERIAL_ADDER_SUB_EN (adds the SUB input).
module serial_adder_sequencer #(
  parameter int N             = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         RST_b,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] OP_A,
  input  logic [N-1:0] OP_B,
  input  logic         CIN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         SUB,
`endif
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         OVF,
  input  real          VDD,
  output real          FA_A,
  output real          FA_B,
  output real          FA_CIN,
  output real          FA_CIN_b,
  input  real          FA_SOUT,
  input  real          FA_COUT
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic           s_bit;
  logic           c_bit;
  logic           b_init;
  logic           c_init;

  // A node is a logic 1 only strictly above mid-rail; a dead supply reads all 0.
  function automatic logic rd(input real v, input real sup);
    return (sup > 0.0) && (v > sup / 2.0);
  endfunction

  assign s_bit = rd(FA_SOUT, VDD);
  assign c_bit = rd(FA_COUT, VDD);

`ifdef SERIAL_ADDER_SUB_EN
  logic [N-1:0] b_in;
  assign b_in   = SUB ? ~OP_B : OP_B;
  assign c_init = SUB ? 1'b1 : CIN;
  assign b_init = 1'b0;
`else
  logic [N-1:0] b_in;
  assign b_in   = OP_B;
  assign c_init = CIN;
  assign b_init = 1'b0;
`endif

  always_comb begin
    FA_A     = 0.0;
    FA_B     = 0.0;
    FA_CIN   = 0.0;
    FA_CIN_b = VDD;
    if (state == RUN) begin
      FA_A     = a_q[idx] ? VDD : 0.0;
      FA_B     = b_q[idx] ? VDD : 0.0;
      FA_CIN   = carry ? VDD : 0.0;
      FA_CIN_b = carry ? 0.0 : VDD;
    end
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      state     <= IDLE;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      SUM       <= '0;
      COUT      <= 1'b0;
      OVF       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            a_q      <= OP_A;
            b_q      <= b_in;
            carry    <= c_init | b_init;
            idx      <= '0;
            cnt      <= '0;
            SUM      <= '0;
            COUT     <= 1'b0;
            OVF      <= 1'b0;
            IN_READY <= 1'b0;
            state    <= RUN;
          end else begin
            IN_READY <= 1'b1;
          end
        end
        RUN: begin
          if (cnt != CW'(SETTLE_CYCLES - 1)) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt      <= '0;
            SUM[idx] <= s_bit;
            carry    <= c_bit;
            if (idx == IW'(N - 1)) begin
              // carry still holds the carry into the MSB here
              OVF       <= carry ^ c_bit;
              COUT      <= c_bit;
              OUT_VALID <= 1'b1;
              state     <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Randomized bench for serial_adder_sequencer with a behavioural CLRCL cell
// and an arithmetic reference model.
module tb_serial_adder_sequencer;

  localparam int N  = 8;
  localparam int SC = 2;

  logic         CLK = 1'b0;
  logic         RST_b = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [N-1:0] OP_A = '0;
  logic [N-1:0] OP_B = '0;
  logic         CIN = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         SUB = 1'b0;
`endif
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [N-1:0] SUM;
  logic         COUT;
  logic         OVF;
  real          VDD = 1.0;
  real          FA_A, FA_B, FA_CIN, FA_CIN_b;
  real          FA_SOUT, FA_COUT;
  real          hi_frac = 1.0;

  int n_chk  = 0;
  int n_pass = 0;

  serial_adder_sequencer #(.N(N), .SETTLE_CYCLES(SC)) dut (
    .CLK(CLK), .RST_b(RST_b),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_A(OP_A), .OP_B(OP_B), .CIN(CIN),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB(SUB),
`endif
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SUM(SUM), .COUT(COUT), .OVF(OVF),
    .VDD(VDD), .FA_A(FA_A), .FA_B(FA_B),
    .FA_CIN(FA_CIN), .FA_CIN_b(FA_CIN_b),
    .FA_SOUT(FA_SOUT), .FA_COUT(FA_COUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural full-adder cell; output high level is VDD*hi_frac
  logic ca, cb, cc;
  always_comb begin
    ca = (VDD > 0.0) && (FA_A > VDD / 2.0);
    cb = (VDD > 0.0) && (FA_B > VDD / 2.0);
    cc = (VDD > 0.0) && (FA_CIN > VDD / 2.0);
    FA_SOUT = (ca ^ cb ^ cc) ? VDD * hi_frac : 0.0;
    FA_COUT = ((ca & cb) | (ca & cc) | (cb & cc)) ? VDD * hi_frac : 0.0;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  function automatic longint mv(input real r);
    return longint'($rtoi(r * 1000.0));
  endfunction

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic ci, input logic sb,
                                output logic [N-1:0] s, output logic co,
                                output logic ov);
    logic [N-1:0] bb;
    logic         c0;
    logic [N:0]   t;
    bb = sb ? ~b : b;
    c0 = sb ? 1'b1 : ci;
    t  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, c0};
    s  = t[N-1:0];
    co = t[N];
    ov = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic sb, input int hold,
                        input bit bit3chk, input bit zero_exp);
    int k;
    logic [N-1:0] es;
    logic eco, eov;
    k = 0;
    while (!IN_READY && k < 50) begin
      @(posedge CLK); #1; k++;
    end
    check("in_ready_idle", IN_READY, 1);
    OP_A = a; OP_B = b; CIN = ci;
`ifdef SERIAL_ADDER_SUB_EN
    SUB = sb;
`endif
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    OP_A = N'($urandom); OP_B = N'($urandom); CIN = 1'($urandom);
    check("in_ready_busy", IN_READY, 0);
    k = 0;
    while (!OUT_VALID && k < 100) begin
      if (bit3chk && (k == 6 || k == 7)) begin
        check("fa_a_bit3", mv(FA_A), mv(VDD));
        check("fa_b_bit3", mv(FA_B), 0);
        check("fa_cin_bit3", mv(FA_CIN), 0);
        check("fa_cinb_bit3", mv(FA_CIN_b), mv(VDD));
      end
      @(posedge CLK); #1; k++;
    end
    check("latency", k, N * SC);
    model(a, b, ci, sb, es, eco, eov);
    if (zero_exp) begin
      es = '0; eco = 1'b0; eov = 1'b0;
    end
    check("sum", SUM, es);
    check("cout", COUT, eco);
    check("ovf", OVF, eov);
    OUT_READY = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_valid", OUT_VALID, 1);
      check("hold_sum", SUM, es);
      check("hold_cout", COUT, eco);
      check("hold_ovf", OVF, eov);
      check("hold_in_ready", IN_READY, 0);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check("out_valid_drop", OUT_VALID, 0);
    check("in_ready_after", IN_READY, 1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_sum", SUM, 0);
    check("rst_fa_a", mv(FA_A), 0);
    check("rst_fa_cinb", mv(FA_CIN_b), 1000);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_b = 1'b1;
    @(posedge CLK); #1;
    check("rel_in_ready", IN_READY, 1);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h81, 8'h80, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    run_op(8'h08, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Abort five cycles into RUN
    OP_A = 8'h77; OP_B = 8'h11; CIN = 1'b0;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST_b = 1'b0;
    #1;
    check("abort_out_valid", OUT_VALID, 0);
    check("abort_sum", SUM, 0);
    check("abort_in_ready", IN_READY, 0);
    check("abort_fa_a", mv(FA_A), 0);
    check("abort_fa_cin", mv(FA_CIN), 0);
    check("abort_fa_cinb", mv(FA_CIN_b), mv(VDD));
    @(negedge CLK) RST_b = 1'b1;
    @(posedge CLK); #1;
    check("abort_rel_ready", IN_READY, 1);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Half-rail supply: the threshold is strictly above 0.25
    VDD = 0.5;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    hi_frac = 0.5;
    run_op(8'hC3, 8'h5F, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    hi_frac = 0.52;
    run_op(8'hC3, 8'h5F, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    hi_frac = 1.0;
    VDD = 0.0;
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    VDD = 1.0;

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 25; t++) begin
      logic sb;
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`endif
      run_op(N'($urandom), N'($urandom), 1'($urandom), sb,
             int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
